// File: rtl/pattern_gen_stream.sv
// pattern_gen_stream: emits a burst of DEPTH test-data words, each tagged with its beat
// address, over a valid/ready stream for the memory write/compare path.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request a burst (accepted only when idle)
//   mode, invert    pattern select and all-ones XOR, latched when start is accepted
//   out_valid/ready stream handshake; data/addr hold while stalled
//   data, addr      pattern word and beat index 0..DEPTH-1
//   busy            high while the burst is streaming
//   done            one-cycle pulse after the last beat is accepted
//
// Optional feature: define PATGEN_LFSR_EN to enable mode 5 (32-bit Fibonacci LFSR,
// x^32+x^22+x^2+x+1). Without it, mode 5 produces the solid all-zeros pattern.
module pattern_gen_stream #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter logic [31:0] SEED   = 32'hACE1_0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        mode,
   input  logic              invert,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done
);

   localparam int unsigned WALK_W = $clog2(DATA_W);
   localparam logic [ADDR_W-1:0] LastBeat = ADDR_W'(DEPTH - 1);
   localparam logic [WALK_W-1:0] LastWalk = WALK_W'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] beat_q, beat_d;
   logic [WALK_W-1:0] walk_q, walk_d;   // k mod DATA_W, wraps independently of addr
   logic [2:0]        mode_q, mode_d;
   logic              invert_q, invert_d;
   logic [DATA_W-1:0] pat;

`ifdef PATGEN_LFSR_EN
   logic [31:0]       lfsr_q, lfsr_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         beat_q   <= '0;
         walk_q   <= '0;
         mode_q   <= '0;
         invert_q <= 1'b0;
`ifdef PATGEN_LFSR_EN
         lfsr_q   <= SEED;
`endif
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         walk_q   <= walk_d;
         mode_q   <= mode_d;
         invert_q <= invert_d;
`ifdef PATGEN_LFSR_EN
         lfsr_q   <= lfsr_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      walk_d   = walk_q;
      mode_d   = mode_q;
      invert_d = invert_q;
`ifdef PATGEN_LFSR_EN
      lfsr_d   = lfsr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d   = mode;
               invert_d = invert;
               beat_d   = '0;
               walk_d   = '0;
`ifdef PATGEN_LFSR_EN
               lfsr_d   = SEED;
`endif
               state_d  = StRun;
            end
         end
         StRun: begin
            if (out_ready) begin
               if (beat_q == LastBeat) begin
                  state_d = StDone;
                  beat_d  = '0;
                  walk_d  = '0;
               end else begin
                  beat_d = beat_q + ADDR_W'(1);
                  walk_d = (walk_q == LastWalk) ? '0 : walk_q + WALK_W'(1);
`ifdef PATGEN_LFSR_EN
                  lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
`endif
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Beat parity is beat_q[0]: the counter never wraps inside a burst.
   always_comb begin
      pat = '0;
      case (mode_q)
         3'd1: pat = beat_q[0] ? '1 : '0;
         3'd2: pat = beat_q[0] ? {(DATA_W / 2){2'b10}} : {(DATA_W / 2){2'b01}};
         3'd3: pat = DATA_W'(1) << walk_q;
         3'd4: pat = ~(DATA_W'(1) << walk_q);
`ifdef PATGEN_LFSR_EN
         3'd5: pat = lfsr_q[DATA_W-1:0];
`endif
         default: pat = '0;
      endcase
   end

   always_comb begin
      out_valid = (state_q == StRun);
      busy      = (state_q == StRun);
      done      = (state_q == StDone);
      data      = out_valid ? (pat ^ {DATA_W{invert_q}}) : '0;
      addr      = out_valid ? beat_q : '0;
   end

endmodule

// File: tb/tb_pattern_gen_stream.sv
module tb_pattern_gen_stream;

   localparam int unsigned DW = 8;
   localparam int unsigned DEP = 10;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    mode = 3'd0;
   logic          invert = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] data;
   logic [AW-1:0] addr;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;
   logic [AW+DW-1:0] exp_q[$];
   logic last_hs = 1'b0;

   pattern_gen_stream #(
      .DATA_W(DW),
      .DEPTH (DEP),
      .ADDR_W(AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .invert   (invert),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .data     (data),
      .addr     (addr),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Ten hand-computed bytes, beat 0 in the most significant byte.
   task automatic push_vec(input logic [8*DEP-1:0] v);
      for (int k = 0; k < int'(DEP); k++)
         exp_q.push_back({AW'(k), v[8*DEP-1-8*k -: 8]});
   endtask

   // Monitor: pops the scoreboard on each handshake; a stalled beat is compared every cycle.
   always @(negedge clk) begin
      if (rst) begin
         last_hs = 1'b0;
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_beat", {addr, data}, 32'hDEAD);
            else begin
               check("beat", {20'd0, addr, data}, {20'd0, exp_q[0]});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (done || last_hs) check("done_pulse", {31'd0, done}, {31'd0, last_hs});
         check("busy", {31'd0, busy}, {31'd0, out_valid});
         last_hs = out_valid && out_ready && (addr == AW'(DEP - 1));
      end
   end

   task automatic burst(input logic [2:0] m, input logic inv, input bit stall, input bit disturb);
      int cycles;
      @(posedge clk); #1;
      mode = m; invert = inv; start = 1'b1; out_ready = stall ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 0;
      forever begin
         @(posedge clk); #1;
         cycles++;
         if (done) break;
         if (cycles > 60) begin
            check("burst_timeout", 32'(cycles), 32'(stall ? 2 * DEP : DEP));
            break;
         end
         if (stall) out_ready = cycles[0];
         if (disturb && cycles == 3) begin
            start = 1'b1; mode = 3'd4; invert = ~inv;
         end
         if (disturb && cycles == 4) start = 1'b0;
      end
      check("burst_cycles", 32'(cycles), 32'(stall ? 2 * DEP : DEP));
      // start during the DONE cycle must not be accepted
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_done_ignored", {30'd0, busy, out_valid}, 32'd0);
      out_ready = 1'b1;
   endtask

   initial begin
      logic [31:0] l;
      logic [8*DEP-1:0] v;
      #1;
      check("rst_outputs", {18'd0, out_valid, busy, done, addr, data}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      push_vec(80'h00FF00FF00FF00FF00FF);                      // toggle
      burst(3'd1, 1'b0, 1'b0, 1'b0);
      push_vec(80'hAA55AA55AA55AA55AA55);                      // checkerboard, inverted, stalled
      burst(3'd2, 1'b1, 1'b1, 1'b0);
      push_vec(80'h01020408102040800102);                      // walking one wraps
      burst(3'd3, 1'b0, 1'b0, 1'b0);
      push_vec(80'hFEFDFBF7EFDFBF7FFEFD);                      // walking zero
      burst(3'd4, 1'b0, 1'b1, 1'b0);
      push_vec(80'hFFFFFFFFFFFFFFFFFFFF);                      // solid, inverted
      burst(3'd0, 1'b1, 1'b0, 1'b0);
      push_vec(80'h0);                                         // reserved mode
      burst(3'd6, 1'b0, 1'b0, 1'b0);
      push_vec(80'h01020408102040800102);                      // start/mode/invert changes ignored
      burst(3'd3, 1'b0, 1'b0, 1'b1);

`ifdef PATGEN_LFSR_EN
      l = 32'hACE1_0001;
      for (int k = 0; k < int'(DEP); k++) begin
         v[8*DEP-1-8*k -: 8] = l[7:0];
         l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      end
      check("lfsr_beat0", {24'd0, v[8*DEP-1 -: 8]}, 32'h01);
`else
      l = 32'd0;
      v = '0;
`endif
      push_vec(v);
      burst(3'd5, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-burst: outputs clear at once, no done pulse afterwards.
      push_vec(80'h00FF00FF00FF00FF00FF);
      @(posedge clk); #1;
      mode = 3'd1; invert = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midburst_rst", {18'd0, out_valid, busy, done, addr, data}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("post_rst_idle", {29'd0, out_valid, busy, done}, 32'd0);
      end

      push_vec(80'hAA55AA55AA55AA55AA55);                      // normal burst after abort
      burst(3'd2, 1'b1, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pattern_gen_stream.md
Name: pattern_gen_stream

Overview:
- Parametrised successor to the fixed 8-bit toggle data generator.
- Produces a burst of DEPTH test-data words, each paired with its address, for the memory controller / BISR write and compare path.
- Offers selectable data patterns and an optional inversion.
- Output is a valid/ready stream, so the memory controller can stall it at any beat.

Parameters:
- DATA_W, 8, data word width; even, 2..32
- DEPTH, 16, words per burst; 2..2^ADDR_W
- ADDR_W, 4, address output width
- SEED, 32'hACE1_0001, LFSR reset/start value; must be nonzero

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request a burst; accepted only in IDLE
- mode  in  3  pattern select; sampled when start is accepted
- invert  in  1  XOR every data word with all-ones; sampled when start is accepted
- out_valid  out  1  data and addr are valid
- out_ready  in  1  consumer accepts the current beat
- data  out  DATA_W  pattern word
- addr  out  ADDR_W  beat index, 0..DEPTH-1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, out_valid=0, data=0, addr=0, busy=0, done=0
  - internal beat counter=0, LFSR=SEED
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches mode and invert, loads beat 0, moves to RUN. Next cycle out_valid=1, addr=0, data=P(0).
  - RUN:
    - out_valid=1, busy=1.
    - data and addr hold stable while out_ready=0.
    - A handshake (out_valid & out_ready) on beat k<DEPTH-1 presents beat k+1 on the next cycle, so back-to-back throughput is 1 word per clock.
    - A handshake on beat DEPTH-1 moves to DONE: out_valid drops to 0 the next cycle.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - start is ignored in RUN and DONE. start in the cycle DONE returns to IDLE is not accepted; it is accepted the following cycle.
- Pattern P(k) before inversion, with k = beat index:
  - mode 0, solid: all zeros
  - mode 1, toggle: even k all zeros, odd k all ones
  - mode 2, checkerboard: even k {DATA_W/2{2'b01}}, odd k {DATA_W/2{2'b10}} (DATA_W=8: 0x55 / 0xAA)
  - mode 3, walking one: 1 << (k mod DATA_W)
  - mode 4, walking zero: ~(1 << (k mod DATA_W))
  - mode 5, LFSR: see Optional Feature
  - modes 6, 7: reserved, behave as mode 0
- Inversion: data = P(k) ^ {DATA_W{invert_latched}}.
- The k mod DATA_W counter wraps independently of addr. addr is truncated to ADDR_W.
- An asynchronous rst mid-burst aborts immediately to reset values. done is not pulsed.
- mode and invert changes during RUN have no effect.

Optional Feature:
- Macro PATGEN_LFSR_EN.
- Defined:
  - mode 5 outputs the low DATA_W bits of a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1.
  - LFSR is loaded with SEED on start acceptance; beat 0 = SEED[DATA_W-1:0].
  - LFSR steps once per handshake, never while stalled.
- Undefined: no LFSR logic; mode 5 behaves as mode 0.

Test Plan:
- rst=1 mid-operation, then released -> all outputs 0, state IDLE, no done pulse.
- DATA_W=8, DEPTH=4, mode=1, invert=0, out_ready=1 -> data 00,FF,00,FF on addr 0..3, consecutive cycles; done pulses one cycle after addr 3.
- mode=2, invert=1, out_ready toggling 1,0,1,0 -> data AA,55,AA,55. Each word holds stable for its stall cycle. Total 8 RUN cycles.
- DEPTH=10, mode=3 -> 01,02,04,08,10,20,40,80,01,02 (walking wraps); mode=4 gives the bitwise complements.
- start pulsed during RUN, and mode changed mid-burst -> ignored; the burst completes with the originally latched pattern.
- With PATGEN_LFSR_EN, mode=5, SEED default:
  - beat 0 = 0x01; stalled beats repeat the same value.
  - Without the macro, mode 5 yields 0x00 on every beat.
